// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Delimits framed debug commands (SYNC, LEN, payload[, CHK]) arriving from the
//   UART receiver FIFO and forwards payload bytes as a valid/ready stream. The
//   final byte of each frame carries frm_last, and frm_err marks a bad frame.
//   Optional feature macro: UART_FRAME_PARSER_CHECKSUM_EN (trailing XOR CHK byte).
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   byte_in_data/valid        byte from upstream FIFO (always accepted)
//   byte_in_ready             read request to upstream FIFO (1-cycle read latency)
//   frm_data/valid/last/err   payload stream out; frm_ready is the downstream accept
//   stat_frames/stat_errors   saturating good / bad frame counters
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned OUT_DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in_data,
  input  logic        byte_in_valid,
  output logic        byte_in_ready,
  output logic [7:0]  frm_data,
  output logic        frm_valid,
  output logic        frm_last,
  output logic        frm_err,
  input  logic        frm_ready,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_errors
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW = $clog2(OUT_DEPTH + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
    , S_CHK
`endif
  } state_e;

  typedef struct packed {
    logic       last;
    logic       err;
    logic [7:0] data;
  } ent_t;

  state_e          state_q, state_d;
  logic [7:0]      rem_q, rem_d;
  logic            held_vld_q, held_vld_d;
  logic [7:0]      held_q, held_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [15:0]     frames_q, frames_d, errors_q, errors_d;
  logic            rdy_q;
  ent_t            mem_q [OUT_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_b_ptr;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW:0]     occ_sum;
  logic            timeout, len_bad, pop;
  logic            push_a, push_b, inc_frames, inc_errors;
  ent_t            ent_a, ent_b, head;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
  logic [7:0]      xor_q, xor_d;
  logic            chk_bad;
  assign chk_bad = (byte_in_data != xor_q);
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign timeout = (state_q != S_IDLE) && (tmo_q == TMO_LAST);
  assign len_bad = (byte_in_data == 8'd0) || (byte_in_data > MAX_LEN_B);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; timeout wins over a byte arriving in the same cycle
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_IDLE;
    end else if (byte_in_valid) begin
      case (state_q)
        S_IDLE:    if (byte_in_data == SYNC_BYTE) state_d = S_LEN;
        S_LEN:     state_d = len_bad ? S_IDLE : S_PAYLOAD;
        S_PAYLOAD: if (rem_q == 8'd1) begin
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_IDLE;
`endif
        end
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
        S_CHK:     state_d = S_IDLE;
`endif
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output / datapath logic. The newest payload byte waits in the hold
  // register so it can be tagged last/err once the frame outcome is known.
  always_comb begin
    push_a     = 1'b0;
    push_b     = 1'b0;
    ent_a      = '0;
    ent_b      = '0;
    inc_frames = 1'b0;
    inc_errors = 1'b0;
    rem_d      = rem_q;
    held_d     = held_q;
    held_vld_d = held_vld_q;
    tmo_d      = (state_q == S_IDLE || byte_in_valid || timeout) ? '0 : tmo_q + 1'b1;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
    xor_d      = (state_q == S_IDLE) ? '0 : xor_q;
`endif
    if (timeout) begin
      inc_errors = 1'b1;
      held_vld_d = 1'b0;
      if (held_vld_q) begin
        push_a = 1'b1;
        ent_a  = '{last: 1'b1, err: 1'b1, data: held_q};
      end
    end else if (byte_in_valid) begin
      case (state_q)
        S_LEN: begin
          if (len_bad) inc_errors = 1'b1;
          else         rem_d = byte_in_data;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
          xor_d = xor_q ^ byte_in_data;
`endif
        end
        S_PAYLOAD: begin
          if (held_vld_q) begin
            push_a = 1'b1;
            ent_a  = '{last: 1'b0, err: 1'b0, data: held_q};
          end
          held_d     = byte_in_data;
          held_vld_d = 1'b1;
          rem_d      = rem_q - 8'd1;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
          xor_d = xor_q ^ byte_in_data;
`else
          if (rem_q == 8'd1) begin
            push_b     = 1'b1;
            ent_b      = '{last: 1'b1, err: 1'b0, data: byte_in_data};
            held_vld_d = 1'b0;
            inc_frames = 1'b1;
          end
`endif
        end
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
        S_CHK: begin
          push_a     = 1'b1;
          ent_a      = '{last: 1'b1, err: chk_bad, data: held_q};
          held_vld_d = 1'b0;
          inc_errors = chk_bad;
          inc_frames = !chk_bad;
        end
`endif
        default: ;
      endcase
    end
    frames_d = (inc_frames && frames_q != '1) ? frames_q + 16'd1 : frames_q;
    errors_d = (inc_errors && errors_q != '1) ? errors_q + 16'd1 : errors_q;
  end

  // Output FIFO bookkeeping: up to two pushes (held + final byte) and one pop per cycle
  always_comb begin
    pop      = (cnt_q != '0) && frm_ready;
    wr_b_ptr = push_a ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    wr_ptr_d = push_b ? ptr_inc(wr_b_ptr) : wr_b_ptr;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push_a) + CW'(push_b) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      held_q     <= '0;
      held_vld_q <= 1'b0;
      tmo_q      <= '0;
      frames_q   <= '0;
      errors_q   <= '0;
      rdy_q      <= 1'b0;
    end else begin
      if (push_a) mem_q[wr_ptr_q] <= ent_a;
      if (push_b) mem_q[wr_b_ptr] <= ent_b;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
      tmo_q      <= tmo_d;
      frames_q   <= frames_d;
      errors_q   <= errors_d;
      rdy_q      <= byte_in_ready;
    end
  end

`ifdef UART_FRAME_PARSER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) xor_q <= '0;
    else     xor_q <= xor_d;
  end
`endif

  // A byte requested last cycle is still in flight; the spare entry absorbs
  // the double push when the final byte releases the hold register as well.
  // Gated by rst so no read request is issued while the parser is held in reset.
  assign occ_sum       = {1'b0, cnt_q} + {{CW{1'b0}}, rdy_q};
  assign byte_in_ready = !rst && (occ_sum < (CW+1)'(OUT_DEPTH - 1));

  assign head        = mem_q[rd_ptr_q];
  assign frm_valid   = (cnt_q != '0);
  assign frm_data    = head.data;
  assign frm_last    = frm_valid & head.last;
  assign frm_err     = frm_valid & head.err;
  assign stat_frames = frames_q;
  assign stat_errors = errors_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: an upstream FIFO model honours byte_in_ready,
// frames are scored into an expected queue as they are queued for sending,
// and a monitor compares every valid output cycle against the queue head.
module tb_uart_frame_parser;

  localparam int unsigned TMO  = 200;
  localparam int unsigned MAXL = 64;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
  localparam bit HAS_CHK = 1'b1;
`else
  localparam bit HAS_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in_data = '0;
  logic        byte_in_valid = 1'b0;
  logic        byte_in_ready;
  logic [7:0]  frm_data;
  logic        frm_valid, frm_last, frm_err;
  logic        frm_ready = 1'b1;
  logic [15:0] stat_frames, stat_errors;

  logic [7:0]  up_q[$];
  logic [9:0]  exp_q[$];
  logic [7:0]  pl [256];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned m_frames = 0;
  int unsigned m_errors = 0;
  int unsigned ready_mode = 0;

  uart_frame_parser #(
    .SYNC_BYTE(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO), .OUT_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .byte_in_data(byte_in_data), .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready),
    .frm_data(frm_data), .frm_valid(frm_valid), .frm_last(frm_last), .frm_err(frm_err),
    .frm_ready(frm_ready), .stat_frames(stat_frames), .stat_errors(stat_errors)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Upstream FIFO: one byte delivered the cycle after byte_in_ready was seen high
  initial begin
    logic pend;
    forever begin
      @(negedge clk);
      pend = byte_in_ready;
      @(posedge clk);
      #1;
      if (pend && up_q.size() != 0) begin
        byte_in_valid = 1'b1;
        byte_in_data  = up_q.pop_front();
      end else begin
        byte_in_valid = 1'b0;
      end
    end
  end

  // Downstream ready: 0 = always, 1 = stalled, 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      frm_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'($urandom_range(1, 0));
    end
  end

  // Output monitor: head must match whenever valid, popped on handshake
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst && frm_valid) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_frm", 32'(frm_valid), 32'd0);
        end else begin
          check_val("frm_out", 32'({frm_last, frm_err, frm_data}), 32'(exp_q[0]));
          if (frm_ready) e = exp_q.pop_front();
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input int unsigned len, input bit corrupt);
    logic [7:0] x;
    logic       bad;
    bad = corrupt && HAS_CHK;
    x   = 8'(len);
    up_q.push_back(8'hA5);
    up_q.push_back(8'(len));
    for (int unsigned i = 0; i < len; i++) begin
      up_q.push_back(pl[i]);
      x = x ^ pl[i];
      if (i == len - 1) exp_q.push_back({1'b1, bad, pl[i]});
      else              exp_q.push_back({2'b00, pl[i]});
    end
    if (HAS_CHK) up_q.push_back(corrupt ? (x ^ 8'h01) : x);
    if (bad) m_errors++;
    else     m_frames++;
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n = 0;
    while ((up_q.size() != 0 || exp_q.size() != 0) && n < 4 * TMO + 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_frames"}, 32'(stat_frames), 32'(m_frames));
    check_val({tag, "_errors"}, 32'(stat_errors), 32'(m_errors));
  endtask

  task automatic reset_checks(input string tag);
    check_val({tag, "_in_ready"}, 32'(byte_in_ready), 32'd0);
    check_val({tag, "_valid"}, 32'(frm_valid), 32'd0);
    check_val({tag, "_last"}, 32'(frm_last), 32'd0);
    check_val({tag, "_err"}, 32'(frm_err), 32'd0);
    check_val({tag, "_frames"}, 32'(stat_frames), 32'd0);
    check_val({tag, "_errors"}, 32'(stat_errors), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("rst0");
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic 3-byte frame
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(3, 1'b0);
    wait_drain("basic");

    // Wrong checksum (plain good frame when no CHK byte is carried)
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    send_frame(2, 1'b1);
    wait_drain("badchk");

    // Zero and oversize LEN, then stray byte
    up_q.push_back(8'hA5); up_q.push_back(8'h00); m_errors++;
    up_q.push_back(8'hA5); up_q.push_back(8'(MAXL + 1)); m_errors++;
    up_q.push_back(8'h7E);
    wait_drain("badlen");

    // Inter-byte timeout with one byte held
    up_q.push_back(8'hA5); up_q.push_back(8'h04); up_q.push_back(8'h01); up_q.push_back(8'h02);
    exp_q.push_back({2'b00, 8'h01});
    exp_q.push_back({2'b11, 8'h02});
    m_errors++;
    wait_drain("timeout");

    // Downstream stall during an 8-byte frame
    ready_mode = 1;
    @(posedge clk);
    for (int unsigned i = 0; i < 8; i++) pl[i] = 8'(8'h40 + i);
    send_frame(8, 1'b0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check_val("stall_in_ready", 32'(byte_in_ready), 32'd0);
    ready_mode = 0;
    wait_drain("stall");

    // Reset in mid-frame drops it
    up_q.push_back(8'hA5); up_q.push_back(8'h05); up_q.push_back(8'h01);
    for (int unsigned n = 0; n < 100 && up_q.size() != 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("rst1");
    m_frames = 0;
    m_errors = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    pl[0] = 8'h55;
    send_frame(1, 1'b0);
    wait_drain("postrst");

    // Max length frame with embedded sync bytes, random backpressure
    ready_mode = 2;
    for (int unsigned i = 0; i < MAXL; i++) pl[i] = (i % 5 == 2) ? 8'hA5 : 8'($urandom);
    send_frame(MAXL, 1'b0);
    wait_drain("maxlen");

    // Random short frames, random checksum corruption
    for (int unsigned f = 0; f < 6; f++) begin
      int unsigned len;
      len = $urandom_range(16, 1);
      for (int unsigned i = 0; i < len; i++) pl[i] = 8'($urandom);
      send_frame(len, 1'($urandom_range(1, 0)));
    end
    wait_drain("random");
    ready_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
